// File: rtl/usb_rx_param.sv
// usb_rx_param: full-speed USB packet receiver with configurable oversampling
// and receive FIFO depth. Recovers bit timing from D+ transitions, NRZI
// decodes, removes stuff bits, checks SYNC, detects EOP and buffers payload
// bytes in a first-word-fall-through FIFO.
//
// Optional build macro: USB_RX_CRC16_EN enables CRC16 residual checking at EOP.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus idle (J); waiting for the first K of SYNC
// SYNC     | assembling the first byte and comparing it to SYNC_BYTE
// RECV     | assembling payload bytes and pushing them into the FIFO
// EOP      | SE0 seen on a byte boundary; waiting for the closing J
// ERR_WAIT | packet failed; discarding data until SE0 followed by J
module usb_rx_param #(
  parameter int          CLKS_PER_BIT = 8,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'h80
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  input  logic       r_enable,
  output logic [7:0] r_data,
  output logic       empty,
  output logic       full,
  output logic       rcving,
  output logic       r_error,
  output logic [7:0] byte_count,
  output logic       pkt_done
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] HALF_LD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LD = TW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_N = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SYNC = 3'd1;
  localparam logic [2:0] ST_RECV = 3'd2;
  localparam logic [2:0] ST_EOP  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  logic          dp_meta, dp_sync, dm_meta, dm_sync, dp_last;
  logic [TW-1:0] bit_tmr;
  logic [2:0]    state;
  logic          prev_smp;
  logic [2:0]    ones_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          byte_valid;
  logic [7:0]    byte_q;
  logic          pkt_err;
  logic          se0_seen;
  logic          crc_ok;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic edge_dp, fall_dp, sample, se0, j_line, smp_se0, smp_j;
  logic dec_bit, smp_data, is_stuff, stuff_err, bit_ok, byte_cmp;
  logic start_pkt, pop, do_push, overflow;
  logic [7:0] next_byte;

  assign edge_dp   = dp_sync ^ dp_last;
  assign fall_dp   = dp_last & ~dp_sync;
  assign sample    = (bit_tmr == '0) && !edge_dp;
  assign se0       = !dp_sync && !dm_sync;
  assign j_line    = dp_sync && !dm_sync;
  assign smp_se0   = sample && se0;
  assign smp_j     = sample && j_line;
  assign dec_bit   = (dp_sync == prev_smp);
  assign smp_data  = sample && !se0 && ((state == ST_SYNC) || (state == ST_RECV));
  assign is_stuff  = (ones_cnt == 3'd6);
  assign stuff_err = smp_data && is_stuff && dec_bit;
  assign bit_ok    = smp_data && !is_stuff;
  assign next_byte = {dec_bit, shreg[7:1]};
  assign byte_cmp  = bit_ok && (bit_cnt == 3'd7);
  assign start_pkt = (state == ST_IDLE) && fall_dp;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_N);
  assign pop      = r_enable && !empty;
  assign do_push  = byte_valid && (!full || pop);
  assign overflow = byte_valid && full && !pop;
  assign r_data   = empty ? 8'h00 : mem[rd_ptr];

  // Two-flop synchronisers on both lines, reset to idle J; dp_last tracks D+ edges.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_meta <= 1'b1;
      dp_sync <= 1'b1;
      dm_meta <= 1'b0;
      dm_sync <= 1'b0;
      dp_last <= 1'b1;
    end else begin
      dp_meta <= d_plus;
      dp_sync <= dp_meta;
      dm_meta <= d_minus;
      dm_sync <= dm_meta;
      dp_last <= dp_sync;
    end
  end

  // Bit timer: a D+ edge reloads half a bit, terminal count reloads a full bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_tmr <= FULL_LD;
    end else if (edge_dp) begin
      bit_tmr <= HALF_LD;
    end else if (bit_tmr == '0) begin
      bit_tmr <= FULL_LD;
    end else begin
      bit_tmr <= bit_tmr - 1'b1;
    end
  end

  // NRZI decode, unstuffing and LSB-first byte assembly.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_smp   <= 1'b1;
      ones_cnt   <= 3'd0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      byte_valid <= 1'b0;
      byte_q     <= 8'h00;
    end else begin
      if (state == ST_IDLE) begin
        prev_smp <= 1'b1;
      end else if (sample) begin
        prev_smp <= dp_sync;
      end
      if (start_pkt) begin
        ones_cnt <= 3'd0;
        bit_cnt  <= 3'd0;
      end else if (smp_data) begin
        if (is_stuff) begin
          ones_cnt <= 3'd0;
        end else begin
          ones_cnt <= dec_bit ? ones_cnt + 3'd1 : 3'd0;
          shreg    <= next_byte;
          bit_cnt  <= bit_cnt + 3'd1;
        end
      end
      byte_valid <= byte_cmp && (state == ST_RECV);
      if (byte_cmp) begin
        byte_q <= next_byte;
      end
    end
  end

  // Packet sequencing, sticky error and done pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      rcving   <= 1'b0;
      r_error  <= 1'b0;
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      se0_seen <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_pkt) begin
            state   <= ST_SYNC;
            rcving  <= 1'b1;
            pkt_err <= 1'b0;
          end
        end
        ST_SYNC: begin
          if (stuff_err) begin
            r_error  <= 1'b1;
            se0_seen <= 1'b0;
            state    <= ST_ERR;
          end else if (smp_se0) begin
            r_error  <= 1'b1;
            se0_seen <= 1'b1;
            state    <= ST_ERR;
          end else if (byte_cmp) begin
            if (next_byte == SYNC_BYTE) begin
              r_error <= 1'b0;
              state   <= ST_RECV;
            end else begin
              r_error  <= 1'b1;
              se0_seen <= 1'b0;
              state    <= ST_ERR;
            end
          end
        end
        ST_RECV: begin
          if (smp_se0) begin
            if (bit_cnt == 3'd0) begin
              state <= ST_EOP;
            end else begin
              r_error  <= 1'b1;
              se0_seen <= 1'b1;
              state    <= ST_ERR;
            end
          end else if (stuff_err) begin
            r_error  <= 1'b1;
            se0_seen <= 1'b0;
            state    <= ST_ERR;
          end
        end
        ST_EOP: begin
          if (smp_j) begin
            rcving   <= 1'b0;
            state    <= ST_IDLE;
            pkt_done <= !pkt_err && crc_ok;
            if (!crc_ok) begin
              r_error <= 1'b1;
            end
          end
        end
        ST_ERR: begin
          if (smp_se0) begin
            se0_seen <= 1'b1;
          end else if (smp_j && se0_seen) begin
            rcving <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A byte that finds the FIFO full is dropped but the packet carries on.
      if (overflow) begin
        r_error <= 1'b1;
        pkt_err <= 1'b1;
      end
    end
  end

  // FIFO pointers, occupancy and per-packet byte counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      byte_count <= 8'h00;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (start_pkt) begin
        byte_count <= 8'h00;
      end else if (do_push && (byte_count != 8'hFF)) begin
        byte_count <= byte_count + 8'd1;
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= byte_q;
    end
  end

`ifdef USB_RX_CRC16_EN
  logic [15:0] crc;
  logic        pid_seen;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[15] ^ d[i]) begin
        r = {r[14:0], 1'b0} ^ 16'h8005;
      end else begin
        r = {r[14:0], 1'b0};
      end
    end
    return r;
  endfunction

  // CRC16 over every received byte after the PID, including dropped ones.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc      <= 16'hFFFF;
      pid_seen <= 1'b0;
    end else if (start_pkt) begin
      crc      <= 16'hFFFF;
      pid_seen <= 1'b0;
    end else if (byte_valid) begin
      if (pid_seen) begin
        crc <= crc16_byte(crc, byte_q);
      end
      pid_seen <= 1'b1;
    end
  end

  assign crc_ok = (crc == 16'h800D);
`else
  assign crc_ok = 1'b1;
`endif

endmodule

// File: tb/tb_usb_rx_param.sv
// Self-checking bench for usb_rx_param: drives line-level USB packets built
// from a byte list (NRZI + bit stuffing done here) and compares the outputs
// against a queue model of the FIFO and the packet rules.
module tb_usb_rx_param;
  localparam int CPB   = 8;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_plus = 1'b1;
  logic       d_minus = 1'b0;
  logic       r_enable = 1'b0;
  logic [7:0] r_data;
  logic       empty, full, rcving, r_error, pkt_done;
  logic [7:0] byte_count;

  usb_rx_param #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'h80)) dut (
    .clk(clk), .n_rst(n_rst), .d_plus(d_plus), .d_minus(d_minus),
    .r_enable(r_enable), .r_data(r_data), .empty(empty), .full(full),
    .rcving(rcving), .r_error(r_error), .byte_count(byte_count), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int pd_cnt = 0;
  bit tx_bits[$];
  logic [7:0] pkt[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) if (pkt_done === 1'b1) pd_cnt++;

  initial begin
    #900us;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) tx_bits.push_back(b[i]);
  endtask

  task automatic drive_sym(input logic dp, input logic dm, input int n);
    d_plus = dp;
    d_minus = dm;
    repeat (n) @(negedge clk);
  endtask

  // Send tx_bits as NRZI with stuffing, then 2-bit SE0 and idle J.
  task automatic transmit(input bit bad_stuff, output bit rcv_mid);
    bit line;
    int ones;
    bit bad_used;
    line = 1'b1;
    ones = 0;
    bad_used = 1'b0;
    rcv_mid = 1'b0;
    for (int i = 0; i < tx_bits.size(); i++) begin
      if (!tx_bits[i]) line = ~line;
      drive_sym(line, ~line, CPB);
      if (i == 8) rcv_mid = rcving;
      ones = tx_bits[i] ? ones + 1 : 0;
      if (ones == 6) begin
        if (bad_stuff && !bad_used) bad_used = 1'b1;
        else line = ~line;
        drive_sym(line, ~line, CPB);
        ones = 0;
      end
    end
    drive_sym(1'b0, 1'b0, 2 * CPB);
    drive_sym(1'b1, 1'b0, 4 * CPB);
    tx_bits.delete();
  endtask

  // Send SYNC + pkt; model stores bytes while FIFO has room, else overflow.
  task automatic run_packet(input string tag);
    int stored;
    bit ovf;
    int pd0;
    bit mid;
    stored = 0;
    ovf = 1'b0;
    add_byte(8'h80);
    foreach (pkt[i]) begin
      add_byte(pkt[i]);
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(pkt[i]);
        stored++;
      end else begin
        ovf = 1'b1;
      end
    end
    pd0 = pd_cnt;
    transmit(1'b0, mid);
    check({tag, "_rcv_mid"}, mid, 1);
    check({tag, "_byte_count"}, byte_count, (stored > 255) ? 255 : stored);
    check({tag, "_r_error"}, r_error, ovf);
    check({tag, "_pkt_done"}, pd_cnt - pd0, ovf ? 0 : 1);
    check({tag, "_rcving"}, rcving, 0);
    check({tag, "_full"}, full, (exp_q.size() == DEPTH) ? 1 : 0);
    pkt.delete();
  endtask

  task automatic drain_check(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 64) begin
      check({tag, "_r_data"}, r_data, exp_q.pop_front());
      r_enable = 1'b1;
      @(negedge clk);
      r_enable = 1'b0;
      guard++;
    end
    check({tag, "_empty"}, empty, 1);
  endtask

  initial begin
    bit mid;
    int pd0;
    int n;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rcving", rcving, 0);
    check("rst_r_error", r_error, 0);
    check("rst_r_data", r_data, 8'h00);
    check("rst_byte_count", byte_count, 0);
    check("rst_pkt_done", pd_cnt, 0);

    // Single data byte A5
    pkt.push_back(8'hA5);
    run_packet("a5");
    check("a5_not_empty", empty, 0);
    check("a5_head", r_data, 8'hA5);
    drain_check("a5");

    // Pop while empty is ignored
    r_enable = 1'b1;
    @(negedge clk);
    r_enable = 1'b0;
    check("pop_empty_empty", empty, 1);
    check("pop_empty_full", full, 0);

    // Bad SYNC byte
    add_byte(8'h00);
    add_byte(8'h55);
    pd0 = pd_cnt;
    transmit(1'b0, mid);
    check("badsync_rcv_mid", mid, 1);
    check("badsync_r_error", r_error, 1);
    check("badsync_empty", empty, 1);
    check("badsync_rcving", rcving, 0);
    check("badsync_pkt_done", pd_cnt - pd0, 0);

    // Long runs of ones with correct stuffing; valid SYNC clears r_error
    pkt.push_back(8'hFF);
    pkt.push_back(8'h3F);
    run_packet("stuff0");
    drain_check("stuff0");

    // Same stream with the first stuff bit sent as 1
    add_byte(8'h80);
    add_byte(8'hFF);
    add_byte(8'h3F);
    pd0 = pd_cnt;
    transmit(1'b1, mid);
    check("stuff1_r_error", r_error, 1);
    check("stuff1_empty", empty, 1);
    check("stuff1_pkt_done", pd_cnt - pd0, 0);
    check("stuff1_rcving", rcving, 0);

    // Partial byte before SE0
    add_byte(8'h80);
    tx_bits.push_back(1'b1);
    tx_bits.push_back(1'b0);
    tx_bits.push_back(1'b1);
    tx_bits.push_back(1'b0);
    pd0 = pd_cnt;
    transmit(1'b0, mid);
    check("partial_r_error", r_error, 1);
    check("partial_byte_count", byte_count, 0);
    check("partial_pkt_done", pd_cnt - pd0, 0);
    check("partial_rcving", rcving, 0);
    check("partial_empty", empty, 1);

    // Overflow: 9 bytes into an 8-deep FIFO
    for (int i = 0; i < 9; i++) pkt.push_back(8'($urandom));
    run_packet("ovf");
    drain_check("ovf");

    // Randomized packets
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      run_packet($sformatf("rnd%0d", k));
      drain_check($sformatf("rnd%0d", k));
    end

`ifdef USB_RX_CRC16_EN
    begin
      logic [15:0] c;
      logic [7:0]  lo, hi;
      logic [7:0]  dat;
      c = 16'hFFFF;
      dat = 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (c[15] ^ dat[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
        else c = {c[14:0], 1'b0};
      end
      for (int j = 0; j < 8; j++) begin
        lo[j] = ~c[15 - j];
        hi[j] = ~c[7 - j];
      end
      pkt.push_back(8'hC3);
      pkt.push_back(dat);
      pkt.push_back(lo);
      pkt.push_back(hi);
      run_packet("crc_ok");
      drain_check("crc_ok");

      add_byte(8'h80);
      add_byte(8'hC3);
      add_byte(dat);
      add_byte(lo);
      add_byte(hi ^ 8'h80);
      pd0 = pd_cnt;
      transmit(1'b0, mid);
      check("crc_bad_r_error", r_error, 1);
      check("crc_bad_pkt_done", pd_cnt - pd0, 0);
      check("crc_bad_byte_count", byte_count, 4);
      repeat (4) begin
        r_enable = 1'b1;
        @(negedge clk);
        r_enable = 1'b0;
      end
      check("crc_bad_drained", empty, 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
